// File: rtl/fmap_bram_arbiter_if.sv
// rtl/fmap_bram_arbiter_if.sv - dual-port feature-map BRAM connection bundle
//
// Purpose: groups the signals between the feature-map BRAM and its arbiter.
// Port A is the read port, port B is the write port; both are clocked by clk.
// Ports (arbiter view):
//   clk, rst_n          clock and active-low reset forwarded to the memory
//   en_a, we_a, addr_a  port A enable / write enable / address
//   data_in_a           port A write data (unused by the arbiter, tied to 0)
//   data_out_a          port A read data, one cycle after en_a
//   en_b, we_b, addr_b  port B enable / write enable / address
//   data_in_b           port B write data
interface dp_bram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  clk;
    logic                  rst_n;
    logic                  en_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_in_a;
    logic [DATA_WIDTH-1:0] data_out_a;
    logic                  en_b;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_in_b;

    modport arbiter (
        output clk, rst_n,
        output en_a, we_a, addr_a, data_in_a,
        input  data_out_a,
        output en_b, we_b, addr_b, data_in_b
    );

    modport memory (
        input  clk, rst_n,
        input  en_a, we_a, addr_a, data_in_a,
        output data_out_a,
        input  en_b, we_b, addr_b, data_in_b
    );
endinterface

// File: rtl/fmap_bram_arbiter.sv
// rtl/fmap_bram_arbiter.sv - two-client read-modify-write arbiter for the feature-map BRAM
//
// Purpose: shares the dual-port feature-map BRAM between the convolution
// engine (saturating accumulate) and the readout stage (read, optional clear).
// Port A only reads, port B only writes; one request is accepted per cycle.
// Pipeline: S0 accept/read, S1 forward+compute, S2 write, S3 last write kept
// for forwarding.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   acc_valid/acc_ready        accumulate request handshake
//   acc_addr, acc_delta        accumulate address and signed addend
//   rd_valid/rd_ready          readout request handshake
//   rd_addr, rd_clear          readout address, write 0 after reading
//   rd_data_valid, rd_data     readout result strobe and value
//   bram                       BRAM connection (arbiter side)
module fmap_bram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic [DATA_WIDTH-1:0] acc_delta,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clear,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    dp_bram_if.arbiter            bram
);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // ---------------------------------------------------------------
    // S0: arbitration and read issue
    // ---------------------------------------------------------------
    logic                  rr_acc;      // 1: acc wins the next contended cycle
    logic                  grant_acc;
    logic                  grant_rd;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] s0_addr;
    logic [ADDR_WIDTH-1:0] addr_a_q;    // keeps addr_a stable while idle

    always_comb begin
        grant_acc = 1'b0;
        grant_rd  = 1'b0;
        if (!rst) begin
            if (acc_valid && (!rd_valid || rr_acc)) begin
                grant_acc = 1'b1;
            end else if (rd_valid) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign acc_ready = grant_acc;
    assign rd_ready  = grant_rd;
    assign accept    = grant_acc | grant_rd;
    assign s0_addr   = grant_acc ? acc_addr : rd_addr;

    // Pointer only moves on contended cycles so a lone client never
    // steals the other client's turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_acc   <= 1'b1;
            addr_a_q <= '0;
        end else begin
            if (acc_valid && rd_valid) begin
                rr_acc <= ~grant_acc;
            end
            if (accept) begin
                addr_a_q <= s0_addr;
            end
        end
    end

    // ---------------------------------------------------------------
    // S1: BRAM data arrives, forwarding, result computation
    // ---------------------------------------------------------------
    logic                  s1_valid;
    logic                  s1_is_acc;
    logic                  s1_clear;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_delta;

    logic                  s2_valid;    // S2 holds a write to commit
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [DATA_WIDTH-1:0] s2_data;

    logic                  s3_valid;    // last committed write
    logic [ADDR_WIDTH-1:0] s3_addr;
    logic [DATA_WIDTH-1:0] s3_data;

    logic [DATA_WIDTH-1:0] fwd_old;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] sat_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_is_acc <= 1'b0;
            s1_clear  <= 1'b0;
            s1_addr   <= '0;
            s1_delta  <= '0;
        end else begin
            s1_valid  <= accept;
            s1_is_acc <= grant_acc;
            s1_clear  <= rd_clear;
            s1_addr   <= s0_addr;
            s1_delta  <= acc_delta;
        end
    end

    // The word read for S1 was sampled one edge before S2's write commits
    // and on the same edge S3's write committed, so both may be stale in
    // data_out_a. S2 is the younger write and therefore wins.
    always_comb begin
        fwd_old = bram.data_out_a;
        if (s2_valid && (s2_addr == s1_addr)) begin
            fwd_old = s2_data;
        end else if (s3_valid && (s3_addr == s1_addr)) begin
            fwd_old = s3_data;
        end
    end

    // One extra bit catches overflow: the top two bits disagree exactly
    // when the true sum left the representable range.
    always_comb begin
        sum     = {fwd_old[DATA_WIDTH-1], fwd_old} + {s1_delta[DATA_WIDTH-1], s1_delta};
        sat_sum = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            sat_sum = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // ---------------------------------------------------------------
    // S2 write stage, S3 forwarding copy, readout result
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            s2_addr       <= '0;
            s2_data       <= '0;
            s3_valid      <= 1'b0;
            s3_addr       <= '0;
            s3_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            // A plain read issues no write, so it never becomes a
            // forwarding source either.
            s2_valid <= s1_valid && (s1_is_acc || s1_clear);
            if (s1_valid && (s1_is_acc || s1_clear)) begin
                s2_addr <= s1_addr;
                s2_data <= s1_is_acc ? sat_sum : '0;
            end

            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_addr <= s2_addr;
                s3_data <= s2_data;
            end

            rd_data_valid <= s1_valid && !s1_is_acc;
            if (s1_valid && !s1_is_acc) begin
                rd_data <= fwd_old;
            end
        end
    end

    // ---------------------------------------------------------------
    // BRAM drive
    // ---------------------------------------------------------------
    assign bram.clk       = clk;
    assign bram.rst_n     = ~rst;
    assign bram.en_a      = accept;
    assign bram.we_a      = 1'b0;
    assign bram.addr_a    = accept ? s0_addr : addr_a_q;
    assign bram.data_in_a = '0;
    // Gated by rst so an in-flight write is dropped at a reset edge.
    assign bram.en_b      = s2_valid & ~rst;
    assign bram.we_b      = s2_valid & ~rst;
    assign bram.addr_b    = s2_addr;
    assign bram.data_in_b = s2_data;

endmodule

// File: tb/tb_fmap_bram_arbiter.sv
// tb/tb_fmap_bram_arbiter.sv - directed self-checking bench for fmap_bram_arbiter
module tb_fmap_bram_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          acc_valid, acc_ready;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_delta;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_clear;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dp_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    fmap_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_addr(acc_addr), .acc_delta(acc_delta),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .bram(bif)
    );

    // BRAM model: 1-cycle read on port A, write on port B, plus bench preload.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_init, pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            we_count = 0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
        end else begin
            if (pl_en) mem[pl_addr] <= pl_data;
            if (bif.en_b && bif.we_b) mem[bif.addr_b] <= bif.data_in_b;
        end
        if (bif.en_a) bif.data_out_a <= mem[bif.addr_a];
    end

    always @(posedge clk) begin
        if (bif.en_b && bif.we_b) we_count <= we_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_acc(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
        acc_addr = a; acc_delta = d; acc_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(negedge clk);
            if (acc_ready === 1'b1) ok = 1'b1;
            tick();
        end
        acc_valid = 1'b0;
    endtask

    task automatic do_rd(input logic [AW-1:0] a, input logic c, output logic [DW-1:0] data, output bit got);
        bit acc_ok;
        rd_addr = a; rd_clear = c; rd_valid = 1'b1; acc_ok = 1'b0; got = 1'b0; data = '0;
        for (int i = 0; i < 4 && !acc_ok; i++) begin
            @(negedge clk);
            if (rd_ready === 1'b1) acc_ok = 1'b1;
            tick();
        end
        rd_valid = 1'b0;
        for (int i = 0; i < 5 && acc_ok && !got; i++) begin
            @(negedge clk);
            if (rd_data_valid === 1'b1) begin
                got = 1'b1;
                data = rd_data;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_init = 1'b1; acc_valid = 1'b1; rd_valid = 1'b1;
        repeat (3) tick();
        mem_init = 1'b0;
        @(negedge clk);
        checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL reset_acc_ready: got %b want 0", acc_ready); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_data_valid: got %b want 0", rd_data_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if ({bif.en_a, bif.we_a, bif.en_b, bif.we_b} !== 4'b0) begin errors++; $display("FAIL reset_bram_ctl: got %b want 0000", {bif.en_a, bif.we_a, bif.en_b, bif.we_b}); end
        checks++; if (bif.rst_n !== 1'b0) begin errors++; $display("FAIL reset_rst_n: got %b want 0", bif.rst_n); end
        tick();
        rst = 1'b0; acc_valid = 1'b0; rd_valid = 1'b0;
        tick();
    endtask

    task automatic test_accumulate;
        acc_valid = 1'b1; acc_addr = 10'd5; acc_delta = 16'd3;
        @(negedge clk);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL acc1_ready: got %b want 1", acc_ready); end
        tick();
        acc_delta = 16'd4;
        @(negedge clk);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL acc2_ready: got %b want 1", acc_ready); end
        tick();
        acc_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd5; rd_clear = 1'b0;
        @(negedge clk);
        checks++; if ({rd_ready, acc_ready} !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b want 10", {rd_ready, acc_ready}); end
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_early: got %b want 0", rd_data_valid); end
        tick();
        @(negedge clk);
        checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL rd_latency_2: got %b want 1", rd_data_valid); end
        checks++; if (rd_data !== 16'd7) begin errors++; $display("FAIL acc_sum: got %0d want 7", rd_data); end
        tick();
        @(negedge clk);
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b want 0", rd_data_valid); end
        tick();
    endtask

    task automatic test_saturation;
        bit ok1, ok2, g;
        logic [DW-1:0] d;
        pl_en = 1'b1; pl_addr = 10'd9; pl_data = 16'h7FF8;
        tick();
        pl_addr = 10'd10; pl_data = 16'h8008;
        tick();
        pl_en = 1'b0;
        do_acc(10'd9, 16'd100, ok1);
        do_acc(10'd10, 16'hFF9C, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL sat_acc_grant: got %b%b want 11", ok1, ok2); end
        do_rd(10'd9, 1'b0, d, g);
        checks++; if (!g || d !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h (valid %b) want 7fff", d, g); end
        do_rd(10'd10, 1'b0, d, g);
        checks++; if (!g || d !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h (valid %b) want 8000", d, g); end
    endtask

    task automatic test_contention;
        bit exp_acc;
        acc_valid = 1'b1; acc_addr = 10'd20; acc_delta = 16'd1;
        rd_valid = 1'b1; rd_addr = 10'd21; rd_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_acc = (i % 2 == 0);
            @(negedge clk);
            checks++; if ({acc_ready, rd_ready} !== {exp_acc, !exp_acc}) begin errors++; $display("FAIL contend_grant_%0d: got acc/rd %b%b want %b%b", i, acc_ready, rd_ready, exp_acc, !exp_acc); end
            tick();
        end
        acc_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) tick();
        checks++; if (mem[20] !== 16'd2) begin errors++; $display("FAIL contend_mem20: got %0d want 2", mem[20]); end
    endtask

    task automatic test_forwarding;
        bit got;
        logic [DW-1:0] d;
        acc_valid = 1'b1; acc_addr = 10'd3; acc_delta = 16'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL fwd_acc_ready_%0d: got %b want 1", i, acc_ready); end
            tick();
        end
        acc_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd3; rd_clear = 1'b1;
        @(negedge clk);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL fwd_rd_ready: got %b want 1", rd_ready); end
        tick();
        rd_valid = 1'b0; got = 1'b0; d = '0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (rd_data_valid === 1'b1) begin got = 1'b1; d = rd_data; end
            tick();
        end
        checks++; if (!got || d !== 16'd3) begin errors++; $display("FAIL fwd_value: got %0d (valid %b) want 3", d, got); end
        do_rd(10'd3, 1'b0, d, got);
        checks++; if (!got || d !== 16'd0) begin errors++; $display("FAIL fwd_cleared: got %0d (valid %b) want 0", d, got); end
        checks++; if (mem[3] !== 16'd0) begin errors++; $display("FAIL fwd_mem3: got %0d want 0", mem[3]); end
    endtask

    task automatic test_read_only;
        int snap;
        bit got;
        logic [DW-1:0] d;
        pl_en = 1'b1; pl_addr = 10'd40; pl_data = 16'd1234;
        tick();
        pl_en = 1'b0;
        tick();
        snap = we_count;
        do_rd(10'd40, 1'b0, d, got);
        repeat (2) tick();
        checks++; if (!got || d !== 16'd1234) begin errors++; $display("FAIL ro_value: got %0d (valid %b) want 1234", d, got); end
        checks++; if (we_count !== snap) begin errors++; $display("FAIL ro_no_write: got %0d writes want 0", we_count - snap); end
        checks++; if (mem[40] !== 16'd1234) begin errors++; $display("FAIL ro_mem40: got %0d want 1234", mem[40]); end
    endtask

    task automatic test_reset_mid;
        int snap;
        // one contended cycle granted to acc leaves the pointer on rd
        acc_valid = 1'b1; acc_addr = 10'd60; acc_delta = 16'd2;
        rd_valid = 1'b1; rd_addr = 10'd61; rd_clear = 1'b0;
        @(negedge clk);
        checks++; if ({acc_ready, rd_ready} !== 2'b10) begin errors++; $display("FAIL pre_contend: got %b%b want 10", acc_ready, rd_ready); end
        tick();
        acc_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) tick();
        snap = we_count;
        acc_valid = 1'b1; acc_addr = 10'd50; acc_delta = 16'd5;
        @(negedge clk);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL mid_acc_ready: got %b want 1", acc_ready); end
        tick();
        acc_valid = 1'b0; rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (we_count !== snap) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", we_count - snap); end
        checks++; if (mem[50] !== 16'd0) begin errors++; $display("FAIL mid_mem50: got %0d want 0", mem[50]); end
        checks++; if ({acc_ready, rd_ready, rd_data_valid} !== 3'b0) begin errors++; $display("FAIL post_rst_strobes: got %b want 000", {acc_ready, rd_ready, rd_data_valid}); end
        checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL post_rst_rd_data: got %h want 0", rd_data); end
        checks++; if ({bif.en_a, bif.en_b, bif.we_b} !== 3'b0) begin errors++; $display("FAIL post_rst_bram_ctl: got %b want 000", {bif.en_a, bif.en_b, bif.we_b}); end
        checks++; if ({bif.addr_b, bif.data_in_b, bif.addr_a} !== '0) begin errors++; $display("FAIL post_rst_buses: got addr_b %h data_in_b %h addr_a %h want 0", bif.addr_b, bif.data_in_b, bif.addr_a); end
        tick();
        acc_valid = 1'b1; acc_addr = 10'd70; acc_delta = 16'd1;
        rd_valid = 1'b1; rd_addr = 10'd71; rd_clear = 1'b0;
        @(negedge clk);
        checks++; if ({acc_ready, rd_ready} !== 2'b10) begin errors++; $display("FAIL post_rst_first_grant: got %b%b want 10", acc_ready, rd_ready); end
        tick();
        acc_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        acc_valid = 1'b0; acc_addr = '0; acc_delta = '0;
        rd_valid = 1'b0; rd_addr = '0; rd_clear = 1'b0;
        test_reset();
        test_accumulate();
        test_saturation();
        test_contention();
        test_forwarding();
        test_read_only();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
